// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and helpers for the lab-board display stages.
package seg7_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic DIG_ONES = 1'b0;
  localparam logic DIG_TENS = 1'b1;

  // Threshold compare and constant subtract; no multiplier or divider needed for 0..31.
  function automatic logic [5:0] bin5_to_bcd(input logic [4:0] value);
    logic [1:0] tens;
    logic [4:0] rem;
    if (value >= 5'd30) begin
      tens = 2'd3;
      rem  = value - 5'd30;
    end else if (value >= 5'd20) begin
      tens = 2'd2;
      rem  = value - 5'd20;
    end else if (value >= 5'd10) begin
      tens = 2'd1;
      rem  = value - 5'd10;
    end else begin
      tens = 2'd0;
      rem  = value;
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debounce, one-cycle pulse on debounced rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= btn;
      sync2      <= sync1;
      level_prev <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Combinational so the capture lands on the edge right after the level flips
  assign press_pulse = level & ~level_prev;

endmodule

// File: rtl/sum_display_7seg.sv
// Captures {cout,s} on a debounced button press and scans it as two decimal digits.
// Build option: define LEADING_ZERO_BLANK_EN to darken the tens digit when it is zero.
module sum_display_7seg
  import seg7_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REFRESH_DIV     = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_btn,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       carry_led
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(REFRESH_DIV - 1);

  logic          press_pulse;
  logic [4:0]    value_q;
  logic [SW-1:0] scan_cnt;
  logic          digit_sel;
  logic [5:0]    bcd;
  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [1:0]    an_d;
  logic [6:0]    seg_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (load_btn),
    .press_pulse(press_pulse)
  );

  always_comb begin
    bcd  = bin5_to_bcd(value_q);
    tens = bcd[5:4];
    ones = bcd[3:0];
    an_d  = 2'b10;
    seg_d = seg_enc(ones);
    if (digit_sel == DIG_TENS) begin
      an_d  = 2'b01;
      seg_d = seg_enc({2'b00, tens});
`ifdef LEADING_ZERO_BLANK_EN
      if (tens == 2'd0) begin
        an_d  = 2'b11;
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      carry_led <= 1'b0;
      scan_cnt  <= '0;
      digit_sel <= DIG_ONES;
      an_n      <= 2'b11;
      seg_n     <= SEG_BLANK;
    end else begin
      if (press_pulse) begin
        value_q   <= {cout_in, sum_in};
        carry_led <= cout_in;
      end
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_sel <= ~digit_sel;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an_n  <= an_d;
      seg_n <= seg_d;
    end
  end

endmodule

// File: tb/tb_sum_display_7seg.sv
// Directed bench for sum_display_7seg with DEBOUNCE_CYCLES=4, REFRESH_DIV=8.
module tb_sum_display_7seg;

  localparam int DB = 4;
  localparam int RD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_btn = 1'b0;
  logic [3:0] sum_in = 4'h0;
  logic       cout_in = 1'b0;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       carry_led;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  sum_display_7seg #(
    .DEBOUNCE_CYCLES(DB),
    .REFRESH_DIV    (RD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_btn (load_btn),
    .sum_in   (sum_in),
    .cout_in  (cout_in),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .carry_led(carry_led)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the edge-k output reflects scan phase ((k-1)/RD)%2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_disp(input string tag, input int tens, input int ones);
    logic [1:0] ea;
    logic [6:0] es;
    if ((((cyc - 1) / RD) % 2) == 0) begin
      ea = 2'b10;
      es = enc(ones);
    end else begin
      ea = 2'b01;
      es = enc(tens);
`ifdef LEADING_ZERO_BLANK_EN
      if (tens == 0) begin
        ea = 2'b11;
        es = 7'h7F;
      end
`endif
    end
    check({tag, "_an"}, 32'(an_n), 32'(ea));
    check({tag, "_seg"}, 32'(seg_n), 32'(es));
  endtask

  task automatic press(input logic [3:0] s, input logic c, input int hold);
    sum_in   = s;
    cout_in  = c;
    load_btn = 1'b1;
    step(hold);
    load_btn = 1'b0;
    step(12);
  endtask

  initial begin
    // 1: reset
    #12;
    check("t1_rst_seg", 32'(seg_n), 32'h7F);
    check("t1_rst_an", 32'(an_n), 32'h3);
    check("t1_rst_led", 32'(carry_led), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("t1_first_an", 32'(an_n), 32'h2);
    check("t1_first_seg", 32'(seg_n), 32'h40);

    // 2: capture 27, latency 7 edges
    sum_in   = 4'hB;
    cout_in  = 1'b1;
    load_btn = 1'b1;
    step(6);
    check("t2_before", 32'(dut.value_q), 32'd0);
    check("t2_led_before", 32'(carry_led), 32'h0);
    step(1);
    check("t2_value", 32'(dut.value_q), 32'd27);
    check("t2_led", 32'(carry_led), 32'h1);
    step(5);
    load_btn = 1'b0;
    step(12);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_disp("t2_disp", 2, 7);
    end

    // 3: bounce shorter than debounce window
    sum_in   = 4'h3;
    cout_in  = 1'b0;
    load_btn = 1'b1; step(3);
    load_btn = 1'b0; step(2);
    load_btn = 1'b1; step(2);
    load_btn = 1'b0; step(20);
    check("t3_value", 32'(dut.value_q), 32'd27);
    check("t3_led", 32'(carry_led), 32'h1);
    check_disp("t3_disp", 2, 7);

    // 4: long hold with changing inputs; pulse-cycle inputs are step 6 -> {1,9}=25
    load_btn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sum_in  = 4'((i + 3) % 16);
      cout_in = ((i % 3) == 0);
      step(1);
      if (i == 6) check("t4_value_at_capture", 32'(dut.value_q), 32'd25);
    end
    check("t4_value_held", 32'(dut.value_q), 32'd25);
    load_btn = 1'b0;
    sum_in   = 4'h0;
    cout_in  = 1'b0;
    step(20);
    check("t4_value_release", 32'(dut.value_q), 32'd25);
    check("t4_led", 32'(carry_led), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_disp("t4_disp", 2, 5);
    end

    // 5: single-digit value
    press(4'h5, 1'b0, 10);
    check("t5_value", 32'(dut.value_q), 32'd5);
    check("t5_led", 32'(carry_led), 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_disp("t5_disp", 0, 5);
    end

    // 6: value 31, then reset during tens phase and mid-press
    press(4'hF, 1'b1, 10);
    check("t6_value", 32'(dut.value_q), 32'd31);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check_disp("t6_disp", 3, 1);
    end
    for (int i = 0; i < 20 && an_n !== 2'b01; i++) step(1);
    check("t6_tens_phase", 32'(an_n), 32'h1);
    load_btn = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_seg", 32'(seg_n), 32'h7F);
    check("t6_rst_an", 32'(an_n), 32'h3);
    check("t6_rst_led", 32'(carry_led), 32'h0);
    check("t6_rst_value", 32'(dut.value_q), 32'd0);
    load_btn = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(20);
    check("t6_after_value", 32'(dut.value_q), 32'd0);
    check("t6_after_led", 32'(carry_led), 32'h0);
    check_disp("t6_after_disp", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
